// File: rtl/serial_digit_adder_pkg.sv
// rtl/serial_digit_adder_pkg.sv - shared FSM encodings and sizing helper for the digit-serial adder
package adder_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A single-digit operation still needs one counter bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_digit_adder_ripple.sv
// rtl/serial_digit_adder_ripple.sv - combinational DIGIT-bit ripple-carry adder slice
module digit_ripple_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]     = x[i] ^ y[i] ^ w_c[i];
    assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
  end

  assign co = w_c[DIGIT];

endmodule

// File: rtl/serial_digit_adder.sv
// rtl/serial_digit_adder.sv - multi-cycle add/subtract, DIGIT bits per clock, valid/ready on both sides
module serial_digit_adder
  import adder_defs::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);
  localparam int MSB  = WIDTH - 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_cout;
  logic             r_ovf;

  logic [DIGIT-1:0] w_x;
  logic [DIGIT-1:0] w_y;
  logic [DIGIT-1:0] w_s;
  logic             w_co;

  assign w_x = r_a[int'(r_cnt)*DIGIT +: DIGIT];
  assign w_y = r_b[int'(r_cnt)*DIGIT +: DIGIT];

  digit_ripple_adder #(.DIGIT(DIGIT)) u_ripple (
    .x  (w_x),
    .y  (w_y),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  // Subtraction is a + ~b + ~cin, so b and cin are inverted once at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= sub ? ~b : b;
            r_carry    <= sub ? ~cin : cin;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_sum[int'(r_cnt)*DIGIT +: DIGIT] <= w_s;
          r_carry <= w_co;
          if (r_cnt == LAST) begin
            // The top bit of the last digit is the result MSB.
            r_cout      <= w_co;
            r_ovf       <= (r_a[MSB] == r_b[MSB]) && (w_s[DIGIT-1] != r_a[MSB]);
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_digit_adder.sv
// tb/tb_serial_digit_adder.sv - self-checking bench for serial_digit_adder over three WIDTH/DIGIT shapes
module tb_serial_digit_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, cin, sub;
  logic [15:0] a, b;
  int          mode;

  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2, co0, co1, co2, of0, of1, of2;
  logic [15:0] s0;
  logic [7:0]  s1, s2;

  logic        cur_in_ready, cur_out_valid, cur_cout, cur_ovf;
  logic [15:0] cur_sum;
  int          cur_w, cur_ndig;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic prev_ov = 1'b0;
  logic [17:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_digit_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && mode == 0), .in_ready(rdy0),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov0), .out_ready(out_ready && mode == 0),
    .sum(s0), .cout(co0), .ovf(of0));

  serial_digit_adder #(.WIDTH(8), .DIGIT(8)) dut8w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && mode == 1), .in_ready(rdy1),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub), .out_valid(ov1), .out_ready(out_ready && mode == 1),
    .sum(s1), .cout(co1), .ovf(of1));

  serial_digit_adder #(.WIDTH(8), .DIGIT(1)) dut8s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && mode == 2), .in_ready(rdy2),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub), .out_valid(ov2), .out_ready(out_ready && mode == 2),
    .sum(s2), .cout(co2), .ovf(of2));

  always_comb begin
    cur_in_ready = rdy0; cur_out_valid = ov0; cur_sum = s0; cur_cout = co0; cur_ovf = of0;
    cur_w = 16; cur_ndig = 4;
    if (mode == 1) begin
      cur_in_ready = rdy1; cur_out_valid = ov1; cur_sum = {8'h00, s1}; cur_cout = co1; cur_ovf = of1;
      cur_w = 8; cur_ndig = 1;
    end else if (mode == 2) begin
      cur_in_ready = rdy2; cur_out_valid = ov2; cur_sum = {8'h00, s2}; cur_cout = co2; cur_ovf = of2;
      cur_w = 8; cur_ndig = 8;
    end
  end

  // Plain integer arithmetic: unsigned result for sum/cout, signed result for overflow.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input logic s, input int w);
    longint m, ux, uy, sx, sy, r, sr;
    logic co, ov;
    m  = longint'(1) << w;
    ux = longint'(x) & (m - 1);
    uy = longint'(y) & (m - 1);
    sx = (ux >= m / 2) ? ux - m : ux;
    sy = (uy >= m / 2) ? uy - m : uy;
    if (!s) begin
      r = ux + uy + longint'(c); co = (r >= m); sr = sx + sy + longint'(c);
    end else begin
      r = ux - uy - longint'(c); co = (r >= 0); sr = sx - sy - longint'(c);
    end
    ov = (sr < -(m / 2)) || (sr >= m / 2);
    return {ov, co, 16'(((r % m) + m) % m)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (mode %0d, cycle %0d)", name, act, exp, mode, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov <= 1'b0;
    end else begin
      if (in_valid && cur_in_ready) begin
        sb.push_back(model(a, b, cin, sub, cur_w));
        acc_cyc = cyc;
      end
      if (cur_out_valid) begin
        if (sb.size() == 0) begin
          chk("out_valid_without_op", 32'(cur_out_valid), 32'd0);
        end else begin
          chk("result_vs_model", {14'd0, cur_ovf, cur_cout, cur_sum}, {14'd0, sb[0]});
          chk("in_ready_in_done", 32'(cur_in_ready), 32'd0);
          if (!prev_ov) chk("latency", 32'(cyc - acc_cyc), 32'(cur_ndig + 1));
          if (out_ready) void'(sb.pop_front());
        end
      end
      prev_ov <= cur_out_valid;
    end
  end

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input logic ts,
                        input int hold, output logic [15:0] rs, output logic rc, output logic ro);
    int n;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    n = 0;
    while (!cur_in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("in_ready_timeout", 32'(cur_in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("in_ready_after_accept", 32'(cur_in_ready), 32'd0);
    n = 0;
    while (!cur_out_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("out_valid_timeout", 32'(cur_out_valid), 32'd1);
    rs = cur_sum; rc = cur_cout; ro = cur_ovf;
    for (int i = 0; i < hold; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = ~cin; sub = ~sub; in_valid = ~in_valid;
      @(posedge clk); #1;
      chk("hold_sum", {16'd0, cur_sum}, {16'd0, rs});
      chk("hold_in_ready", 32'(cur_in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_after_release", {30'd0, cur_out_valid, cur_in_ready}, 32'd1);
  endtask

  logic [15:0] rs;
  logic        rc, ro;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; mode = 0;
    repeat (2) @(posedge clk); #1;
    chk("reset_outputs", {13'd0, cur_in_ready, cur_out_valid, cur_cout, cur_ovf, cur_sum}, {13'd0, 1'b1, 3'b000, 16'h0000});
    rst_n = 1'b1;
    @(posedge clk); #1;

    chk("model_add", {14'd0, model(16'h1234, 16'h0FCC, 1'b1, 1'b0, 16)}, {14'd0, 2'b00, 16'h2201});
    chk("model_carry", {14'd0, model(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16)}, {14'd0, 2'b01, 16'h0000});
    chk("model_sub_borrow", {14'd0, model(16'h0005, 16'h0007, 1'b0, 1'b1, 16)}, {14'd0, 2'b00, 16'hFFFE});
    chk("model_sub_ovf", {14'd0, model(16'h8000, 16'h0001, 1'b0, 1'b1, 16)}, {14'd0, 2'b11, 16'h7FFF});

    run_op(16'h1234, 16'h0FCC, 1'b1, 1'b0, 0, rs, rc, ro);
    chk("add_literal", {14'd0, ro, rc, rs}, {14'd0, 2'b00, 16'h2201});

    // Reset mid-BUSY: a non-zero previous result must be cleared immediately.
    a = 16'h4321; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {13'd0, cur_in_ready, cur_out_valid, cur_cout, cur_ovf, cur_sum}, {13'd0, 1'b1, 3'b000, 16'h0000});
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, rs, rc, ro);
    chk("carry_all_digits", {14'd0, ro, rc, rs}, {14'd0, 2'b01, 16'h0000});
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, rs, rc, ro);
    chk("signed_ovf_add", {14'd0, ro, rc, rs}, {14'd0, 2'b10, 16'h8000});
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, rs, rc, ro);
    chk("sub_borrow", {14'd0, ro, rc, rs}, {14'd0, 2'b00, 16'hFFFE});
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, rs, rc, ro);
    chk("signed_ovf_sub", {14'd0, ro, rc, rs}, {14'd0, 2'b11, 16'h7FFF});
    run_op(16'h1234, 16'h0FCC, 1'b1, 1'b0, 10, rs, rc, ro);
    chk("backpressure_result", {14'd0, ro, rc, rs}, {14'd0, 2'b00, 16'h2201});
    run_op(16'h00FF, 16'h0F01, 1'b0, 1'b0, 0, rs, rc, ro);
    chk("after_backpressure", {14'd0, ro, rc, rs}, {14'd0, 2'b00, 16'h1000});

    for (int m = 0; m < 3; m++) begin
      mode = m;
      @(posedge clk); #1;
      for (int i = 0; i < ((m == 0) ? 100 : 500); i++) begin
        run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 2), rs, rc, ro);
      end
    end

    mode = 2;
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, rs, rc, ro);
    chk("w8_d1_carry", {14'd0, ro, rc, rs}, {14'd0, 2'b01, 16'h0000});
    mode = 1;
    run_op(16'h0080, 16'h0001, 1'b0, 1'b1, 0, rs, rc, ro);
    chk("w8_d8_sub_ovf", {14'd0, ro, rc, rs}, {14'd0, 2'b11, 16'h007F});

    repeat (2) @(posedge clk); #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
